// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: shared encodings for the debug UART transmit path
package uart_dbg_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARMED     = 2'b01,
    WAIT_DONE = 2'b10,
    RELEASE   = 2'b11
  } arb_state_t;
  localparam int DEF_DATA_W    = 8;
  localparam int REQ_DEBUGGER  = 0;
  localparam int REQ_STEP_DUMP = 1;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner, searching from the slot after last
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);
  always_comb begin
    win = '0;
    idx = '0;
    // descending offsets so the nearest requester after last is assigned last
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) begin
        win = '0;
        win[(int'(last) + i) % N] = 1'b1;
        idx = IW'((int'(last) + i) % N);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic round-robin sharing of one UART transmitter with a done watchdog
module uart_tx_arbiter
  import uart_dbg_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TMO_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0]        i_valid,
  input  logic [N_REQ-1:0]        i_last,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  output logic [N_REQ-1:0]        o_grant,
  output logic [N_REQ-1:0]        o_ready,
  output logic [DATA_W-1:0]       o_data_send,
  output logic                    o_tx_start,
  input  logic                    i_tx_done,
  output logic                    o_busy,
  output logic                    o_timeout
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  arb_state_t state, state_n;
  logic [N_REQ-1:0] grant_n, ready_n, pick;
  logic [IW-1:0] gidx, gidx_n, last_grant, last_grant_n, pick_idx;
  logic [DATA_W-1:0] data_n;
  logic last_q, last_n, tx_start_n, timeout_n;
  logic [TMO_W-1:0] wdog, wdog_n;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req (i_req),
    .last(last_grant),
    .win (pick),
    .idx (pick_idx)
  );

  always_comb begin
    state_n      = state;
    grant_n      = o_grant;
    gidx_n       = gidx;
    last_grant_n = last_grant;
    data_n       = o_data_send;
    last_n       = last_q;
    tx_start_n   = 1'b0;
    ready_n      = '0;
    timeout_n    = 1'b0;
    wdog_n       = '0;
    case (state)
      IDLE: if (|i_req) begin
        state_n = ARMED;
        grant_n = pick;
        gidx_n  = pick_idx;
      end
      ARMED: if (i_valid[gidx]) begin
        data_n     = i_data[int'(gidx)*DATA_W +: DATA_W];
        last_n     = i_last[gidx];
        tx_start_n = 1'b1;
        ready_n    = o_grant;
        state_n    = WAIT_DONE;
      end else if (!i_req[gidx]) begin
        state_n = RELEASE;
      end
      WAIT_DONE: begin
        wdog_n = wdog + 1'b1;
        // done wins over a simultaneous watchdog expiry; ignored while start is still high
        if (i_tx_done && !o_tx_start) begin
          state_n = last_q ? RELEASE : ARMED;
          wdog_n  = '0;
        end else if (&wdog_n) begin
          timeout_n = 1'b1;
          state_n   = RELEASE;
          wdog_n    = '0;
        end
      end
      RELEASE: begin
        grant_n      = '0;
        last_grant_n = gidx;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      o_grant     <= '0;
      o_ready     <= '0;
      o_data_send <= '0;
      o_tx_start  <= 1'b0;
      o_timeout   <= 1'b0;
      wdog        <= '0;
      gidx        <= '0;
      last_grant  <= IW'(N_REQ - 1);
      last_q      <= 1'b0;
    end else begin
      state       <= state_n;
      o_grant     <= grant_n;
      o_ready     <= ready_n;
      o_data_send <= data_n;
      o_tx_start  <= tx_start_n;
      o_timeout   <= timeout_n;
      wdog        <= wdog_n;
      gidx        <= gidx_n;
      last_grant  <= last_grant_n;
      last_q      <= last_n;
    end
  end

  assign o_busy = state != IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed corner cases plus a randomized packet stream checked by a transaction model
module tb_uart_tx_arbiter;
  localparam int N = 2;
  logic clk = 1'b0, rst = 1'b0, i_tx_done = 1'b0;
  logic [N-1:0] i_req = '0, i_valid = '0, i_last = '0, o_grant, o_ready;
  logic [N*8-1:0] i_data = '0;
  logic [7:0] o_data_send;
  logic o_tx_start, o_busy, o_timeout;
  int n_cmp = 0, n_bad = 0, c = 0;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(8), .TMO_W(4)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_valid(i_valid), .i_last(i_last),
    .i_data(i_data), .o_grant(o_grant), .o_ready(o_ready), .o_data_send(o_data_send),
    .o_tx_start(o_tx_start), .i_tx_done(i_tx_done), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, c, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    c++;
  endtask

  function automatic int rr(input int last, input logic [N-1:0] req);
    for (int i = 1; i <= N; i++) if (req[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  logic [7:0] bq[N][$];
  int lq[N][$];
  int left[N], start_at[N];
  logic [7:0] pat[3];
  logic [N-1:0] eg, req_prev;
  int lastg, free_at, exp_start, done_at, rel_at, w, n, len, pending;
  bit is_last, saw_start;

  initial begin
    pat = '{8'hA1, 8'hB2, 8'hC3};
    step(); step();
    check("rst_vals", 32'({o_grant, o_ready, o_data_send, o_tx_start, o_busy, o_timeout}), 0);
    rst = 1'b1;
    // watchdog expiry with no done, then the other requester is served normally
    i_req = 2'b01; i_valid = 2'b01; i_last = 2'b01; i_data = 16'h003C;
    step();
    check("wd_grant", 32'(o_grant), 32'h1);
    step();
    check("wd_start", 32'({o_tx_start, o_ready, o_data_send}), 32'({1'b1, 2'b01, 8'h3C}));
    i_req = '0; i_valid = '0; i_last = '0;
    n = 0;
    while (!o_timeout && n < 40) begin step(); n++; end
    check("wd_lat", n, 15);
    check("wd_busy", 32'(o_busy), 1);
    step();
    check("wd_release", 32'({o_grant, o_timeout}), 0);
    i_req = 2'b10; i_valid = 2'b10; i_last = 2'b10; i_data = 16'h5A00;
    step();
    check("wd_next_grant", 32'(o_grant), 32'h2);
    step();
    check("wd_next_start", 32'({o_tx_start, o_ready, o_data_send}), 32'({1'b1, 2'b10, 8'h5A}));
    i_req = '0; i_valid = '0; i_last = '0;
    step();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    check("wd_no_timeout", 32'({o_timeout, o_busy}), 32'h1);
    step();
    check("wd_idle", 32'({o_grant, o_busy}), 0);
    // reset in the middle of a packet
    i_req = 2'b01; i_valid = 2'b01; i_last = 2'b01; i_data = 16'h00A7;
    step(); step();
    check("mid_start", 32'({o_tx_start, o_data_send}), 32'({1'b1, 8'hA7}));
    i_valid = '0; i_req = 2'b11;
    step();
    rst = 1'b0;
    step();
    check("mid_rst_vals", 32'({o_grant, o_ready, o_data_send, o_tx_start, o_busy, o_timeout}), 0);
    rst = 1'b1;
    step();
    check("mid_rst_grant", 32'(o_grant), 32'h1);
    // abort: granted requester withdraws before presenting a byte
    i_req = '0;
    saw_start = 1'b0;
    step(); saw_start |= o_tx_start;
    step(); saw_start |= o_tx_start;
    check("abort_nostart", 32'(saw_start), 0);
    check("abort_idle", 32'({o_grant, o_busy}), 0);
    // stray done while idle
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    check("stray_done", 32'({o_grant, o_busy, o_tx_start, o_timeout}), 0);
    step();
    check("stray_done2", 32'({o_grant, o_busy, o_tx_start}), 0);
    // randomized packet stream; requester 1 joins while requester 0 is mid-packet
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      start_at[k] = (k == 0) ? 0 : 3;
      left[k] = 0;
      for (int p = 0; p < 6; p++) begin
        len = (k == 0 && p == 0) ? 3 : int'($urandom_range(1, 3));
        lq[k].push_back(len);
        for (int b = 0; b < len; b++) bq[k].push_back((k == 0 && p == 0) ? pat[b] : 8'($urandom));
      end
    end
    eg = '0; req_prev = '0; lastg = N - 1; free_at = 0;
    exp_start = -9; done_at = -9; rel_at = -9; w = 0; is_last = 1'b0;
    c = 0; pending = 1;
    while (c < 3000) begin
      if (c == rel_at) begin eg = '0; free_at = c + 1; end
      if (eg == '0 && c >= free_at && req_prev != '0) begin
        w = rr(lastg, req_prev);
        lastg = w;
        eg = '0;
        eg[w] = 1'b1;
        exp_start = c + 1;
      end
      check("grant", 32'(o_grant), 32'(eg));
      check("busy", 32'(o_busy), 32'(eg != '0));
      check("start", 32'(o_tx_start), 32'(c == exp_start));
      check("ready", 32'(o_ready), (c == exp_start) ? 32'(eg) : 0);
      if (c == exp_start) begin
        check("data", 32'(o_data_send), 32'(bq[w][0]));
        void'(bq[w].pop_front());
        left[w]--;
        is_last = left[w] == 0;
        done_at = c + int'($urandom_range(2, 10));
      end
      if (c == done_at) begin
        if (is_last) rel_at = c + 1;
        else exp_start = c + 1;
      end
      pending = 0;
      for (int k = 0; k < N; k++) begin
        if (left[k] == 0 && lq[k].size() > 0 && c >= start_at[k]) left[k] = lq[k].pop_front();
        pending += left[k] + lq[k].size();
        i_req[k] = left[k] > 0;
        i_valid[k] = left[k] > 0;
        i_last[k] = left[k] == 1;
        i_data[k*8 +: 8] = (left[k] > 0) ? bq[k][0] : 8'h00;
      end
      i_tx_done = (c + 1 == done_at);
      req_prev = i_req;
      if (pending == 0 && eg == '0 && c > rel_at + 2) break;
      step();
    end
    check("drain", pending, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
